pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_pkg.sv | 31 +++
 rtl/pipe_hazard.sv | 32 +++
 rtl/pipe_ctrl.sv | 155 +++++++++++++++
 tb/tb_pipe_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared encodings for the pipeline control slice: instruction codes,
// status codes, the register-none value and the control FSM state type.
package pipe_pkg;

    localparam logic [3:0] I_HALT   = 4'd0;
    localparam logic [3:0] I_MRMOVQ = 4'd5;
    localparam logic [3:0] I_OPQ    = 4'd6;
    localparam logic [3:0] I_JXX    = 4'd7;
    localparam logic [3:0] I_RET    = 4'd9;
    localparam logic [3:0] I_POPQ   = 4'd11;

    localparam logic [3:0] R_NONE   = 4'd15;

    localparam logic [2:0] S_AOK    = 3'd1;
    localparam logic [2:0] S_HLT    = 3'd2;
    localparam logic [2:0] S_ADR    = 3'd3;
    localparam logic [2:0] S_INS    = 3'd4;

    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    // True for the statuses that stop the pipeline (HLT, ADR, INS).
    function automatic logic is_exc(input logic [2:0] s);
        return (s == S_HLT) || (s == S_ADR) || (s == S_INS);
    endfunction

endpackage

// File: rtl/pipe_hazard.sv
// Hazard detection: load/use interlock, pending return, branch mispredict.
// Ports: i_D/E/M_icode, i_E_dstM, i_d_srcA/B, i_e_Cnd -> o_load_use, o_ret_pend, o_mispred.
module pipe_hazard
    import pipe_pkg::*;
(
    input  logic [3:0] i_D_icode,
    input  logic [3:0] i_E_icode,
    input  logic [3:0] i_M_icode,
    input  logic [3:0] i_E_dstM,
    input  logic [3:0] i_d_srcA,
    input  logic [3:0] i_d_srcB,
    input  logic       i_e_Cnd,
    output logic       o_load_use,
    output logic       o_ret_pend,
    output logic       o_mispred
);

    logic w_is_load;
    logic w_dst_hit;

    assign w_is_load  = (i_E_icode == I_MRMOVQ) || (i_E_icode == I_POPQ);
    assign w_dst_hit  = (i_E_dstM != R_NONE) &&
                        ((i_E_dstM == i_d_srcA) || (i_E_dstM == i_d_srcB));
    assign o_load_use = w_is_load && w_dst_hit;

    assign o_ret_pend = (i_D_icode == I_RET) ||
                        (i_E_icode == I_RET) ||
                        (i_M_icode == I_RET);

    assign o_mispred  = (i_E_icode == I_JXX) && !i_e_Cnd;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: stall/bubble generation, fetch PC register, RUN/HALTED
// FSM and optional performance counters (enabled by PIPE_PERF_CNT_EN).
// Inputs: clk, reset (sync, active-high), stage icodes, hazard operands,
//   e_Cnd, m_stat, W_stat, f_predPC.
// Outputs: F_predPC, stall/bubble/set_cc controls, halted, halt_stat,
//   cycle_cnt, stall_cnt, bubble_cnt.
module pipe_ctrl
    import pipe_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  D_icode,
    input  logic [3:0]  E_icode,
    input  logic [3:0]  M_icode,
    input  logic [3:0]  E_dstM,
    input  logic [3:0]  d_srcA,
    input  logic [3:0]  d_srcB,
    input  logic        e_Cnd,
    input  logic [2:0]  m_stat,
    input  logic [2:0]  W_stat,
    input  logic [63:0] f_predPC,
    output logic [63:0] F_predPC,
    output logic        F_stall,
    output logic        D_stall,
    output logic        D_bubble,
    output logic        E_bubble,
    output logic        M_bubble,
    output logic        W_stall,
    output logic        set_cc,
    output logic        halted,
    output logic [2:0]  halt_stat,
    output logic [31:0] cycle_cnt,
    output logic [31:0] stall_cnt,
    output logic [31:0] bubble_cnt
);

    state_t      r_state;
    logic [2:0]  r_halt_stat;
    logic [63:0] r_pc;

    logic w_load_use;
    logic w_ret_pend;
    logic w_mispred;
    logic w_m_exc;
    logic w_w_exc;

    pipe_hazard u_hazard (
        .i_D_icode  (D_icode),
        .i_E_icode  (E_icode),
        .i_M_icode  (M_icode),
        .i_E_dstM   (E_dstM),
        .i_d_srcA   (d_srcA),
        .i_d_srcB   (d_srcB),
        .i_e_Cnd    (e_Cnd),
        .o_load_use (w_load_use),
        .o_ret_pend (w_ret_pend),
        .o_mispred  (w_mispred)
    );

    assign w_m_exc = is_exc(m_stat);
    assign w_w_exc = is_exc(W_stat);

    always_comb begin
        F_stall  = 1'b0;
        D_stall  = 1'b0;
        D_bubble = 1'b0;
        E_bubble = 1'b0;
        M_bubble = 1'b0;
        W_stall  = 1'b0;
        set_cc   = 1'b0;
        if (r_state == ST_HALTED) begin
            F_stall = 1'b1;
            D_stall = 1'b1;
            W_stall = 1'b1;
        end else begin
            F_stall  = w_load_use || w_ret_pend;
            D_stall  = w_load_use;
            // A mispredict squashes decode even while a load/use stalls it.
            D_bubble = w_mispred || (w_ret_pend && !w_load_use);
            E_bubble = w_mispred || w_load_use;
            M_bubble = w_m_exc || w_w_exc;
            W_stall  = w_w_exc;
            set_cc   = (E_icode == I_OPQ) && !w_m_exc && !w_w_exc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= 64'd0;
        end else if (!F_stall) begin
            r_pc <= f_predPC;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_RUN;
            r_halt_stat <= S_AOK;
        end else begin
            unique case (r_state)
                ST_RUN: begin
                    if (W_stat != S_AOK) begin
                        r_state     <= ST_HALTED;
                        r_halt_stat <= W_stat;
                    end
                end
                ST_HALTED: begin
                    r_state <= ST_HALTED;
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    assign F_predPC  = r_pc;
    assign halted    = (r_state == ST_HALTED);
    assign halt_stat = r_halt_stat;

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_stall_cnt;
    logic [31:0] r_bubble_cnt;
    logic        w_run;

    assign w_run = (r_state == ST_RUN);

    // Counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycle_cnt  <= 32'd0;
            r_stall_cnt  <= 32'd0;
            r_bubble_cnt <= 32'd0;
        end else if (w_run) begin
            if (r_cycle_cnt != CNT_MAX) begin
                r_cycle_cnt <= r_cycle_cnt + 32'd1;
            end
            if (F_stall && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if ((D_bubble || E_bubble) && (r_bubble_cnt != CNT_MAX)) begin
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
            end
        end
    end

    assign cycle_cnt  = r_cycle_cnt;
    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
`else
    assign cycle_cnt  = 32'd0;
    assign stall_cnt  = 32'd0;
    assign bubble_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  D_icode, E_icode, M_icode;
    logic [3:0]  E_dstM, d_srcA, d_srcB;
    logic        e_Cnd;
    logic [2:0]  m_stat, W_stat;
    logic [63:0] f_predPC;
    logic [63:0] F_predPC;
    logic        F_stall, D_stall, D_bubble, E_bubble, M_bubble;
    logic        W_stall, set_cc, halted;
    logic [2:0]  halt_stat;
    logic [31:0] cycle_cnt, stall_cnt, bubble_cnt;

    pipe_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .D_icode    (D_icode),
        .E_icode    (E_icode),
        .M_icode    (M_icode),
        .E_dstM     (E_dstM),
        .d_srcA     (d_srcA),
        .d_srcB     (d_srcB),
        .e_Cnd      (e_Cnd),
        .m_stat     (m_stat),
        .W_stat     (W_stat),
        .f_predPC   (f_predPC),
        .F_predPC   (F_predPC),
        .F_stall    (F_stall),
        .D_stall    (D_stall),
        .D_bubble   (D_bubble),
        .E_bubble   (E_bubble),
        .M_bubble   (M_bubble),
        .W_stall    (W_stall),
        .set_cc     (set_cc),
        .halted     (halted),
        .halt_stat  (halt_stat),
        .cycle_cnt  (cycle_cnt),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
    );

    always #5 clk = ~clk;

`ifdef PIPE_PERF_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    bit          m_valid = 1'b0;
    bit          m_halted;
    logic [2:0]  m_hstat;
    logic [63:0] m_pc;
    longint      m_cyc, m_stl, m_bub;
    // Expected combinational outputs for the current cycle
    bit e_fs, e_ds, e_db, e_eb, e_mb, e_ws, e_cc;

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic bit exc(input logic [2:0] s);
        return (s >= 3'd2) && (s <= 3'd4);
    endfunction

    function automatic logic [31:0] cnt_exp(input longint v);
        if (!CNT_ON) return 32'd0;
        return (v > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
    endfunction

    task automatic model_eval();
        bit lu, rp, mp;
        lu = (E_icode == 4'd5 || E_icode == 4'd11) && E_dstM != 4'd15 &&
             (E_dstM == d_srcA || E_dstM == d_srcB);
        rp = (D_icode == 4'd9) || (E_icode == 4'd9) || (M_icode == 4'd9);
        mp = (E_icode == 4'd7) && !e_Cnd;
        if (m_halted) begin
            {e_fs, e_ds, e_ws} = 3'b111;
            {e_db, e_eb, e_mb, e_cc} = 4'b0000;
        end else begin
            e_fs = lu || rp;
            e_ds = lu;
            e_db = mp || (rp && !lu);
            e_eb = mp || lu;
            e_mb = exc(m_stat) || exc(W_stat);
            e_ws = exc(W_stat);
            e_cc = (E_icode == 4'd6) && !exc(m_stat) && !exc(W_stat);
        end
    endtask

    task automatic model_clock();
        if (reset) begin
            m_valid  = 1'b1;
            m_halted = 1'b0;
            m_hstat  = 3'd1;
            m_pc     = 64'd0;
            m_cyc = 0; m_stl = 0; m_bub = 0;
        end else if (m_valid) begin
            if (!e_fs) m_pc = f_predPC;
            if (!m_halted) begin
                m_cyc++;
                if (e_fs) m_stl++;
                if (e_db || e_eb) m_bub++;
                if (W_stat != 3'd1) begin
                    m_halted = 1'b1;
                    m_hstat  = W_stat;
                end
            end
        end
    endtask

    task automatic compare();
        chk("F_stall", F_stall, e_fs);
        chk("D_stall", D_stall, e_ds);
        chk("D_bubble", D_bubble, e_db);
        chk("E_bubble", E_bubble, e_eb);
        chk("M_bubble", M_bubble, e_mb);
        chk("W_stall", W_stall, e_ws);
        chk("set_cc", set_cc, e_cc);
        chk("halted", halted, m_halted);
        chk("halt_stat", halt_stat, m_hstat);
        chk("F_predPC", F_predPC, m_pc);
        chk("cycle_cnt", cycle_cnt, cnt_exp(m_cyc));
        chk("stall_cnt", stall_cnt, cnt_exp(m_stl));
        chk("bubble_cnt", bubble_cnt, cnt_exp(m_bub));
    endtask

    // Let inputs settle, then check everything against the model.
    task automatic settle();
        #2;
        model_eval();
        if (m_valid) compare();
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
        #2;
    endtask

    task automatic idle();
        reset = 1'b0;
        D_icode = 4'd1; E_icode = 4'd1; M_icode = 4'd1;
        E_dstM = 4'd15; d_srcA = 4'd15; d_srcB = 4'd15;
        e_Cnd = 1'b1; m_stat = 3'd1; W_stat = 3'd1;
    endtask

    function automatic logic [3:0] rnd_icode();
        logic [3:0] tbl [8] = '{4'd0, 4'd1, 4'd5, 4'd6, 4'd7, 4'd9, 4'd11, 4'd2};
        return tbl[$urandom_range(0, 7)];
    endfunction

    function automatic logic [3:0] rnd_reg();
        return ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] pc0;
        logic [31:0] b0;
        idle();
        reset = 1'b1;
        f_predPC = 64'h40;
        @(posedge clk);
        model_clock();
        #2;
        reset = 1'b0;
        settle();
        chk("rst_pc", F_predPC, 64'd0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_hstat", halt_stat, 3'd1);
        chk("rst_cyc", cycle_cnt, 32'd0);
        tick();

        // Load/use: fetch PC must hold
        idle(); f_predPC = 64'h100; settle(); tick();
        pc0 = F_predPC;
        E_icode = 4'd5; E_dstM = 4'd3; d_srcA = 4'd3; f_predPC = 64'h200;
        settle();
        chk("lu_fs", F_stall, 1'b1);
        chk("lu_ds", D_stall, 1'b1);
        chk("lu_eb", E_bubble, 1'b1);
        chk("lu_db", D_bubble, 1'b0);
        tick();
        chk("lu_pc_hold", F_predPC, 64'h100);

        // Mispredict, then load/use on d_srcB
        idle(); E_icode = 4'd7; e_Cnd = 1'b0; settle();
        chk("mp_db", D_bubble, 1'b1);
        chk("mp_eb", E_bubble, 1'b1);
        chk("mp_fs", F_stall, 1'b0);
        tick();
        E_icode = 4'd5; E_dstM = 4'd2; d_srcB = 4'd2; settle();
        chk("lub_eb", E_bubble, 1'b1);
        chk("lub_ds", D_stall, 1'b1);
        tick();

        // Return walking down D, E, M
        b0 = bubble_cnt;
        idle(); D_icode = 4'd9; settle();
        chk("retD_fs", F_stall, 1'b1); chk("retD_db", D_bubble, 1'b1);
        tick();
        idle(); E_icode = 4'd9; settle();
        chk("retE_fs", F_stall, 1'b1); chk("retE_db", D_bubble, 1'b1);
        tick();
        idle(); M_icode = 4'd9; settle();
        chk("retM_fs", F_stall, 1'b1); chk("retM_db", D_bubble, 1'b1);
        tick();
        idle(); settle();
        chk("ret_bub", bubble_cnt, CNT_ON ? b0 + 32'd3 : 32'd0);
        tick();

        // Memory exception, then writeback exception halts
        idle(); m_stat = 3'd3; E_icode = 4'd6; settle();
        chk("mx_cc", set_cc, 1'b0);
        chk("mx_mb", M_bubble, 1'b1);
        tick();
        idle(); W_stat = 3'd3; settle();
        chk("wx_halted_pre", halted, 1'b0);
        tick();
        idle(); settle();
        chk("wx_halted", halted, 1'b1);
        chk("wx_hstat", halt_stat, 3'd3);
        chk("wx_fs", F_stall, 1'b1);
        tick();
        settle();
        chk("wx_absorb", halted, 1'b1);

        // Reset out of HALTED
        reset = 1'b1; tick();
        reset = 1'b0; f_predPC = 64'h14; settle();
        chk("rr_pc", F_predPC, 64'd0);
        chk("rr_halted", halted, 1'b0);
        chk("rr_cyc", cycle_cnt, 32'd0);
        chk("rr_bub", bubble_cnt, 32'd0);
        tick();
        settle();
        chk("rr_pc14", F_predPC, 64'h14);
        tick();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset    = ($urandom_range(0, 99) < (m_halted ? 15 : 1));
            D_icode  = rnd_icode();
            E_icode  = rnd_icode();
            M_icode  = rnd_icode();
            E_dstM   = rnd_reg();
            d_srcA   = rnd_reg();
            d_srcB   = rnd_reg();
            e_Cnd    = 1'($urandom_range(0, 1));
            m_stat   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'd1;
            W_stat   = ($urandom_range(0, 39) == 0) ? 3'($urandom_range(0, 7)) : 3'd1;
            f_predPC = {32'($urandom), 32'($urandom)};
            settle();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
